// File: rtl/global_buffer_param.sv
// Shared global-buffer parameters: tile count, register port widths and register indices.
package global_buffer_param;

  localparam int unsigned NUM_GLB_TILES  = 16;
  localparam int unsigned CFG_ADDR_WIDTH = 8;
  localparam int unsigned CFG_DATA_WIDTH = 32;

  // Word index is taken from byte-address bits [4:2].
  localparam int unsigned REG_IDX_LSB   = 2;
  localparam int unsigned REG_IDX_WIDTH = 3;

  // IER bit positions.
  localparam int unsigned IER_F2G  = 0;
  localparam int unsigned IER_G2F  = 1;
  localparam int unsigned IER_PCFG = 2;
  localparam int unsigned IER_WIDTH = 3;

  typedef enum logic [REG_IDX_WIDTH-1:0] {
    REG_STRM_START = 3'd0,
    REG_PC_START   = 3'd1,
    REG_IER        = 3'd2,
    REG_F2G_ISR    = 3'd3,
    REG_G2F_ISR    = 3'd4,
    REG_PCFG_ISR   = 3'd5,
    REG_PC_BUSY    = 3'd6,
    REG_UNMAPPED   = 3'd7
  } reg_idx_e;

  // Zero-extend a per-tile vector to register data width.
  function automatic logic [CFG_DATA_WIDTH-1:0] tiles_to_data(input logic [NUM_GLB_TILES-1:0] t);
    return CFG_DATA_WIDTH'(t);
  endfunction

endpackage

// File: rtl/glb_isr_bank.sv
// Per-tile interrupt status register: bits set on a pulse, cleared by write-1-to-clear.
// A set and a clear on the same bit in the same cycle leaves the bit set.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   set_bits       per-tile interrupt pulses
//   clr_bits       per-tile W1C mask (already qualified by the register write decode)
//   status         registered status bits
module glb_isr_bank
  import global_buffer_param::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_GLB_TILES-1:0] set_bits,
  input  logic [NUM_GLB_TILES-1:0] clr_bits,
  output logic [NUM_GLB_TILES-1:0] status
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status <= '0;
    end else begin
      status <= (status & ~clr_bits) | set_bits;
    end
  end

endmodule

// File: rtl/glb_intr_start_ctrl.sv
// Global-buffer control stage: decodes host register writes into per-tile stream and
// parallel-config start pulses, tracks per-tile pc busy, collects tile done pulses into
// W1C status registers and drives one maskable level interrupt.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cfg_wr_en / cfg_rd_en      register write / read strobes
//   cfg_addr, cfg_wr_data      byte address (bits [4:2] decode) and write data
//   cfg_rd_data(_valid)        registered read data, valid for one cycle after cfg_rd_en
//   strm_start_pulse           1-cycle per-tile stream start
//   pc_start_pulse             1-cycle per-tile parallel-config start (busy tiles dropped)
//   *_interrupt_pulse          per-tile done pulses from the tiles
//   interrupt                  registered level interrupt to the host
module glb_intr_start_ctrl
  import global_buffer_param::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_wr_en,
  input  logic                      cfg_rd_en,
  input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_wr_data,
  output logic [CFG_DATA_WIDTH-1:0] cfg_rd_data,
  output logic                      cfg_rd_data_valid,
  output logic [NUM_GLB_TILES-1:0]  strm_start_pulse,
  output logic [NUM_GLB_TILES-1:0]  pc_start_pulse,
  input  logic [NUM_GLB_TILES-1:0]  strm_f2g_interrupt_pulse,
  input  logic [NUM_GLB_TILES-1:0]  strm_g2f_interrupt_pulse,
  input  logic [NUM_GLB_TILES-1:0]  pcfg_g2f_interrupt_pulse,
  output logic                      interrupt
);

  reg_idx_e                 reg_idx_c;
  logic [NUM_GLB_TILES-1:0] wr_tiles_c;

  logic [NUM_GLB_TILES-1:0] strm_start_c;
  logic [NUM_GLB_TILES-1:0] pc_start_c;
  logic                     ier_we_c;
  logic [NUM_GLB_TILES-1:0] f2g_clr_c;
  logic [NUM_GLB_TILES-1:0] g2f_clr_c;
  logic [NUM_GLB_TILES-1:0] pcfg_clr_c;
  logic [CFG_DATA_WIDTH-1:0] rd_mux_c;

  logic [NUM_GLB_TILES-1:0] pc_busy;
  logic [IER_WIDTH-1:0]     ier;
  logic [NUM_GLB_TILES-1:0] f2g_isr;
  logic [NUM_GLB_TILES-1:0] g2f_isr;
  logic [NUM_GLB_TILES-1:0] pcfg_isr;

  // Address bits outside [4:2] and data bits above the tile range carry no meaning.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{cfg_addr[CFG_ADDR_WIDTH-1:REG_IDX_LSB+REG_IDX_WIDTH],
                             cfg_addr[REG_IDX_LSB-1:0],
                             cfg_wr_data[CFG_DATA_WIDTH-1:NUM_GLB_TILES]};

  assign reg_idx_c  = reg_idx_e'(cfg_addr[REG_IDX_LSB +: REG_IDX_WIDTH]);
  assign wr_tiles_c = cfg_wr_data[NUM_GLB_TILES-1:0];

  // Write decode: start masks, IER enable and W1C masks for the status banks.
  always_comb begin
    strm_start_c = '0;
    pc_start_c   = '0;
    ier_we_c     = 1'b0;
    f2g_clr_c    = '0;
    g2f_clr_c    = '0;
    pcfg_clr_c   = '0;
    if (cfg_wr_en) begin
      case (reg_idx_c)
        REG_STRM_START: strm_start_c = wr_tiles_c;
        // Busy tiles are dropped using the busy state before this write.
        REG_PC_START:   pc_start_c   = wr_tiles_c & ~pc_busy;
        REG_IER:        ier_we_c     = 1'b1;
        REG_F2G_ISR:    f2g_clr_c    = wr_tiles_c;
        REG_G2F_ISR:    g2f_clr_c    = wr_tiles_c;
        REG_PCFG_ISR:   pcfg_clr_c   = wr_tiles_c;
        default:        ;
      endcase
    end
  end

  // Read mux over current (pre-write) register values.
  always_comb begin
    rd_mux_c = '0;
    case (reg_idx_c)
      REG_IER:      rd_mux_c = CFG_DATA_WIDTH'(ier);
      REG_F2G_ISR:  rd_mux_c = tiles_to_data(f2g_isr);
      REG_G2F_ISR:  rd_mux_c = tiles_to_data(g2f_isr);
      REG_PCFG_ISR: rd_mux_c = tiles_to_data(pcfg_isr);
      REG_PC_BUSY:  rd_mux_c = tiles_to_data(pc_busy);
      default:      rd_mux_c = '0;
    endcase
  end

  // Start pulses, busy tracking (start wins over pcfg done), IER, interrupt and read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strm_start_pulse  <= '0;
      pc_start_pulse    <= '0;
      pc_busy           <= '0;
      ier               <= '0;
      interrupt         <= 1'b0;
      cfg_rd_data       <= '0;
      cfg_rd_data_valid <= 1'b0;
    end else begin
      strm_start_pulse  <= strm_start_c;
      pc_start_pulse    <= pc_start_c;
      pc_busy           <= (pc_busy & ~pcfg_g2f_interrupt_pulse) | pc_start_c;
      if (ier_we_c) begin
        ier <= cfg_wr_data[IER_WIDTH-1:0];
      end
      interrupt         <= ((|f2g_isr)  & ier[IER_F2G])
                         | ((|g2f_isr)  & ier[IER_G2F])
                         | ((|pcfg_isr) & ier[IER_PCFG]);
      cfg_rd_data       <= cfg_rd_en ? rd_mux_c : '0;
      cfg_rd_data_valid <= cfg_rd_en;
    end
  end

  glb_isr_bank u_f2g_isr (
    .clk      (clk),
    .reset    (reset),
    .set_bits (strm_f2g_interrupt_pulse),
    .clr_bits (f2g_clr_c),
    .status   (f2g_isr)
  );

  glb_isr_bank u_g2f_isr (
    .clk      (clk),
    .reset    (reset),
    .set_bits (strm_g2f_interrupt_pulse),
    .clr_bits (g2f_clr_c),
    .status   (g2f_isr)
  );

  glb_isr_bank u_pcfg_isr (
    .clk      (clk),
    .reset    (reset),
    .set_bits (pcfg_g2f_interrupt_pulse),
    .clr_bits (pcfg_clr_c),
    .status   (pcfg_isr)
  );

endmodule

// File: tb/tb_glb_intr_start_ctrl.sv
// Bench for glb_intr_start_ctrl: directed scenarios plus randomized traffic against a
// per-tile behavioural model of the register map, start/busy rules and interrupt level.
module tb_glb_intr_start_ctrl;
  import global_buffer_param::*;

  localparam int unsigned N = NUM_GLB_TILES;
  localparam int unsigned D = CFG_DATA_WIDTH;
  localparam int unsigned A = CFG_ADDR_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_wr_en;
  logic         cfg_rd_en;
  logic [A-1:0] cfg_addr;
  logic [D-1:0] cfg_wr_data;
  logic [D-1:0] cfg_rd_data;
  logic         cfg_rd_data_valid;
  logic [N-1:0] strm_start_pulse;
  logic [N-1:0] pc_start_pulse;
  logic [N-1:0] f2g;
  logic [N-1:0] g2f;
  logic [N-1:0] pcfg;
  logic         interrupt;

  always #5 clk = ~clk;

  glb_intr_start_ctrl dut (
    .clk                      (clk),
    .reset                    (reset),
    .cfg_wr_en                (cfg_wr_en),
    .cfg_rd_en                (cfg_rd_en),
    .cfg_addr                 (cfg_addr),
    .cfg_wr_data              (cfg_wr_data),
    .cfg_rd_data              (cfg_rd_data),
    .cfg_rd_data_valid        (cfg_rd_data_valid),
    .strm_start_pulse         (strm_start_pulse),
    .pc_start_pulse           (pc_start_pulse),
    .strm_f2g_interrupt_pulse (f2g),
    .strm_g2f_interrupt_pulse (g2f),
    .pcfg_g2f_interrupt_pulse (pcfg),
    .interrupt                (interrupt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state, one bit per tile.
  bit m_busy[N];
  bit m_isr[3][N];
  bit m_ier[3];

  // Expected outputs after the most recent step().
  logic [N-1:0] e_strm;
  logic [N-1:0] e_pc;
  logic         e_int;
  logic         e_rd_valid;
  logic [D-1:0] e_rd_data;

  function automatic logic [D-1:0] m_read(input int idx);
    logic [D-1:0] v;
    v = '0;
    if (idx == 2) begin
      for (int k = 0; k < 3; k++) v[k] = m_ier[k];
    end else if (idx >= 3 && idx <= 5) begin
      for (int t = 0; t < N; t++) v[t] = m_isr[idx-3][t];
    end else if (idx == 6) begin
      for (int t = 0; t < N; t++) v[t] = m_busy[t];
    end
    return v;
  endfunction

  task automatic m_clear();
    for (int t = 0; t < N; t++) begin
      m_busy[t] = 1'b0;
      for (int k = 0; k < 3; k++) m_isr[k][t] = 1'b0;
    end
    for (int k = 0; k < 3; k++) m_ier[k] = 1'b0;
    e_strm = '0; e_pc = '0; e_int = 1'b0; e_rd_valid = 1'b0; e_rd_data = '0;
  endtask

  task automatic idle_inputs();
    cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
    f2g = '0; g2f = '0; pcfg = '0;
  endtask

  // Advance one clock: model consumes the current inputs, then the DUT edge happens.
  task automatic step();
    int           idx;
    bit           wr;
    bit           any_int;
    logic [D-1:0] dat;
    logic [N-1:0] pv[3];
    idx = int'(cfg_addr[4:2]);
    wr  = cfg_wr_en;
    dat = cfg_wr_data;
    pv[0] = f2g; pv[1] = g2f; pv[2] = pcfg;
    e_rd_valid = cfg_rd_en;
    e_rd_data  = cfg_rd_en ? m_read(idx) : '0;
    any_int = 1'b0;
    for (int k = 0; k < 3; k++)
      for (int t = 0; t < N; t++)
        if (m_isr[k][t] && m_ier[k]) any_int = 1'b1;
    e_int = any_int;
    for (int t = 0; t < N; t++) begin
      e_strm[t] = wr && idx == 0 && dat[t];
      e_pc[t]   = wr && idx == 1 && dat[t] && !m_busy[t];
      if (e_pc[t]) m_busy[t] = 1'b1;
      else if (pcfg[t]) m_busy[t] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (pv[k][t]) m_isr[k][t] = 1'b1;
        else if (wr && idx == 3 + k && dat[t]) m_isr[k][t] = 1'b0;
      end
    end
    if (wr && idx == 2)
      for (int k = 0; k < 3; k++) m_ier[k] = dat[k];
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic set_addr(input int idx);
    cfg_addr = A'($urandom);
    cfg_addr[4:2] = 3'(idx);
  endtask

  task automatic wr_reg(input int idx, input logic [D-1:0] data);
    cfg_wr_en = 1'b1; set_addr(idx); cfg_wr_data = data;
    step();
  endtask

  task automatic rd_reg(input int idx);
    cfg_rd_en = 1'b1; set_addr(idx);
    step();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cfg_addr = '0; cfg_wr_data = '0;
    reset = 1'b1;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({strm_start_pulse, pc_start_pulse, interrupt, cfg_rd_data_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got strm=%h pc=%h int=%b vld=%b, required all 0",
               strm_start_pulse, pc_start_pulse, interrupt, cfg_rd_data_valid);
    end
    n_tests++;
    if (cfg_rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h required 0", cfg_rd_data);
    end
    reset = 1'b0;
    step();
    // Reset arriving while a STRM_START write is pending must not let a pulse out.
    cfg_wr_en = 1'b1; set_addr(0); cfg_wr_data = D'(32'h5);
    #3 reset = 1'b1;
    m_clear();
    @(posedge clk);
    #1;
    idle_inputs();
    n_tests++;
    if (strm_start_pulse !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_write_in_reset: got %h required 0", strm_start_pulse);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (strm_start_pulse !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_write_after_%0d: got %h required 0", i, strm_start_pulse);
      end
    end
  endtask

  task automatic test_strm_start();
    wr_reg(0, D'(32'h3));
    n_tests++;
    if (strm_start_pulse !== N'(16'h0003)) begin
      n_fail++;
      $display("FAIL strm_start_pulse: got %h required 0003", strm_start_pulse);
    end
    step();
    n_tests++;
    if (strm_start_pulse !== '0) begin
      n_fail++;
      $display("FAIL strm_start_one_cycle: got %h required 0000", strm_start_pulse);
    end
  endtask

  task automatic test_pc_start();
    wr_reg(1, D'(32'h1));
    n_tests++;
    if (pc_start_pulse !== N'(16'h0001)) begin
      n_fail++;
      $display("FAIL pc_start_first: got %h required 0001", pc_start_pulse);
    end
    rd_reg(6);
    n_tests++;
    if (cfg_rd_data !== D'(32'h1) || cfg_rd_data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pc_busy_after_first: got %h vld=%b required 00000001 vld=1",
               cfg_rd_data, cfg_rd_data_valid);
    end
    wr_reg(1, D'(32'h1));
    n_tests++;
    if (pc_start_pulse !== '0) begin
      n_fail++;
      $display("FAIL pc_start_while_busy: got %h required 0000", pc_start_pulse);
    end
    rd_reg(6);
    n_tests++;
    if (cfg_rd_data !== D'(32'h1)) begin
      n_fail++;
      $display("FAIL pc_busy_after_second: got %h required 00000001", cfg_rd_data);
    end
    pcfg = N'(16'h0001);
    step();
    rd_reg(6);
    n_tests++;
    if (cfg_rd_data !== '0) begin
      n_fail++;
      $display("FAIL pc_busy_after_pcfg: got %h required 00000000", cfg_rd_data);
    end
    wr_reg(1, D'(32'h1));
    n_tests++;
    if (pc_start_pulse !== N'(16'h0001)) begin
      n_fail++;
      $display("FAIL pc_start_third: got %h required 0001", pc_start_pulse);
    end
  endtask

  task automatic test_f2g_intr();
    wr_reg(2, D'(32'h1));
    f2g = N'(16'h0010);
    step();
    step();
    n_tests++;
    if (interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL f2g_interrupt_set: got %b required 1", interrupt);
    end
    rd_reg(3);
    n_tests++;
    if (cfg_rd_data !== D'(32'h10) || cfg_rd_data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL f2g_isr_read: got %h vld=%b required 00000010 vld=1",
               cfg_rd_data, cfg_rd_data_valid);
    end
    wr_reg(3, D'(32'h10));
    step();
    n_tests++;
    if (interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL f2g_interrupt_clear: got %b required 0", interrupt);
    end
  endtask

  task automatic test_g2f_mask();
    g2f = N'(16'h0004);
    step();
    step();
    n_tests++;
    if (interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL g2f_masked_interrupt: got %b required 0", interrupt);
    end
    rd_reg(4);
    n_tests++;
    if (cfg_rd_data !== D'(32'h4)) begin
      n_fail++;
      $display("FAIL g2f_isr_read: got %h required 00000004", cfg_rd_data);
    end
    wr_reg(2, D'(32'h3));
    step();
    n_tests++;
    if (interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL g2f_unmasked_interrupt: got %b required 1", interrupt);
    end
  endtask

  task automatic test_pcfg_collision();
    wr_reg(5, D'(32'hFFFF));
    cfg_wr_en = 1'b1; set_addr(5); cfg_wr_data = D'(32'h80);
    pcfg = N'(16'h0080);
    step();
    rd_reg(5);
    n_tests++;
    if (cfg_rd_data !== D'(32'h80)) begin
      n_fail++;
      $display("FAIL pcfg_set_wins: got %h required 00000080", cfg_rd_data);
    end
    cfg_rd_en = 1'b1; cfg_addr = A'(8'h1C);
    step();
    n_tests++;
    if (cfg_rd_data !== '0 || cfg_rd_data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h vld=%b required 00000000 vld=1",
               cfg_rd_data, cfg_rd_data_valid);
    end
    step();
    n_tests++;
    if (cfg_rd_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_valid_one_cycle: got %b required 0", cfg_rd_data_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end
      cfg_wr_en   = 1'($urandom_range(0, 1));
      cfg_rd_en   = 1'($urandom_range(0, 1));
      cfg_addr    = A'($urandom);
      cfg_wr_data = D'($urandom);
      f2g  = ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom) : '0;
      g2f  = ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom) : '0;
      pcfg = ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom) : '0;
      step();
      n_tests++;
      if (strm_start_pulse !== e_strm) begin
        n_fail++;
        $display("FAIL rand_strm[%0d]: got %h required %h", i, strm_start_pulse, e_strm);
      end
      n_tests++;
      if (pc_start_pulse !== e_pc) begin
        n_fail++;
        $display("FAIL rand_pc[%0d]: got %h required %h", i, pc_start_pulse, e_pc);
      end
      n_tests++;
      if (interrupt !== e_int) begin
        n_fail++;
        $display("FAIL rand_int[%0d]: got %b required %b", i, interrupt, e_int);
      end
      n_tests++;
      if (cfg_rd_data_valid !== e_rd_valid || cfg_rd_data !== e_rd_data) begin
        n_fail++;
        $display("FAIL rand_read[%0d]: got %h vld=%b required %h vld=%b",
                 i, cfg_rd_data, cfg_rd_data_valid, e_rd_data, e_rd_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_strm_start();
    test_pc_start();
    test_f2g_intr();
    test_g2f_mask();
    test_pcfg_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
